// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between an instruction-fetch (I) and a data (D) requester.
// Define MEM_ARB_PERF_CNT_EN to add the wait-cycle and timeout performance counters.
module mem_port_arbiter #(
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter int unsigned MAX_D_BURST = 4,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  output logic          i_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic          m_gnt,
  input  logic          m_rvalid,
  input  logic [DW-1:0] m_rdata
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]   perf_i_wait,
  output logic [31:0]   perf_d_wait,
  output logic [15:0]   perf_timeout
`endif
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_RESP = 2'd2} state_e;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_I = 2'd1, OWN_D = 2'd2} owner_e;

  localparam logic [3:0] BURST_MAX = 4'(MAX_D_BURST);
  localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);

  state_e          state_q, state_d;
  owner_e          owner_q, owner_d;
  logic [3:0]      burst_q, burst_d;
  logic [7:0]      to_q, to_d;
  logic            m_req_q, m_req_d, m_we_q, m_we_d;
  logic [AW-1:0]   m_addr_q, m_addr_d;
  logic [DW-1:0]   m_wdata_q, m_wdata_d;
  logic            i_rvalid_q, i_rvalid_d, i_err_q, i_err_d;
  logic            d_rvalid_q, d_rvalid_d, d_err_q, d_err_d;
  logic [DW-1:0]   i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic            d_wins_s, timeout_s;

  // D has priority unless it has already won MAX_D_BURST times in a row over a waiting I.
  assign d_wins_s = d_req && !(i_req && (burst_q == BURST_MAX));

  // Next-state, arbitration and completion logic.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    burst_d    = burst_q;
    to_d       = to_q;
    m_req_d    = m_req_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    i_rvalid_d = 1'b0;
    i_err_d    = 1'b0;
    i_rdata_d  = i_rdata_q;
    d_rvalid_d = 1'b0;
    d_err_d    = 1'b0;
    d_rdata_d  = d_rdata_q;
    timeout_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (d_wins_s) begin
          state_d   = S_REQ;
          owner_d   = OWN_D;
          m_req_d   = 1'b1;
          m_we_d    = d_we;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          if (i_req) begin
            burst_d = (burst_q == BURST_MAX) ? burst_q : burst_q + 4'd1;
          end else begin
            burst_d = 4'd0;
          end
        end else if (i_req) begin
          state_d   = S_REQ;
          owner_d   = OWN_I;
          m_req_d   = 1'b1;
          m_we_d    = 1'b0;
          m_addr_d  = i_addr;
          m_wdata_d = '0;
          burst_d   = 4'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (m_gnt) begin
          state_d = S_RESP;
          m_req_d = 1'b0;
          to_d    = 8'd0;
        end else begin
          state_d = S_REQ;
        end
      end
      S_RESP: begin
        to_d = to_q + 8'd1;
        // A real completion on the last allowed cycle still wins over the timeout.
        if (m_rvalid || (to_q == TO_LAST)) begin
          state_d   = S_IDLE;
          owner_d   = OWN_NONE;
          timeout_s = !m_rvalid;
          case (owner_q)
            OWN_I: begin
              i_rvalid_d = 1'b1;
              i_err_d    = !m_rvalid;
              i_rdata_d  = m_rvalid ? m_rdata : '0;
            end
            OWN_D: begin
              d_rvalid_d = 1'b1;
              d_err_d    = !m_rvalid;
              d_rdata_d  = m_rvalid ? m_rdata : '0;
            end
            default: begin
              state_d = S_IDLE;
            end
          endcase
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
        owner_d = OWN_NONE;
        m_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      owner_q    <= OWN_NONE;
      burst_q    <= 4'd0;
      to_q       <= 8'd0;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      i_rvalid_q <= 1'b0;
      i_err_q    <= 1'b0;
      i_rdata_q  <= '0;
      d_rvalid_q <= 1'b0;
      d_err_q    <= 1'b0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      burst_q    <= burst_d;
      to_q       <= to_d;
      m_req_q    <= m_req_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      i_rvalid_q <= i_rvalid_d;
      i_err_q    <= i_err_d;
      i_rdata_q  <= i_rdata_d;
      d_rvalid_q <= d_rvalid_d;
      d_err_q    <= d_err_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  // Grants follow m_gnt in the same cycle, so they are decoded rather than registered.
  assign i_gnt    = (state_q == S_REQ) && (owner_q == OWN_I) && m_gnt;
  assign d_gnt    = (state_q == S_REQ) && (owner_q == OWN_D) && m_gnt;
  assign i_rvalid = i_rvalid_q;
  assign i_err    = i_err_q;
  assign i_rdata  = i_rdata_q;
  assign d_rvalid = d_rvalid_q;
  assign d_err    = d_err_q;
  assign d_rdata  = d_rdata_q;
  assign m_req    = m_req_q;
  assign m_we     = m_we_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] perf_i_wait_q, perf_d_wait_q;
  logic [15:0] perf_timeout_q;

  // Wrapping wait-cycle and timeout counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_i_wait_q  <= 32'd0;
      perf_d_wait_q  <= 32'd0;
      perf_timeout_q <= 16'd0;
    end else begin
      perf_i_wait_q  <= perf_i_wait_q + {31'd0, (i_req && !i_gnt)};
      perf_d_wait_q  <= perf_d_wait_q + {31'd0, (d_req && !d_gnt)};
      perf_timeout_q <= perf_timeout_q + {15'd0, timeout_s};
    end
  end

  assign perf_i_wait  = perf_i_wait_q;
  assign perf_d_wait  = perf_d_wait_q;
  assign perf_timeout = perf_timeout_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: transaction-level reference model plus directed scenarios.
module tb_mem_port_arbiter;
  localparam int MAXB = 4;
  localparam int TO   = 8;

  logic clk = 1'b0, rst_n = 1'b0;
  logic i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, m_gnt = 1'b0, m_rvalid = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, m_rdata = '0;
  logic i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err, m_req, m_we;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] perf_i_wait, perf_d_wait;
  logic [15:0] perf_timeout;
`endif

  mem_port_arbiter #(.AW(32), .DW(32), .MAX_D_BURST(MAXB), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .d_err(d_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_gnt(m_gnt), .m_rvalid(m_rvalid),
    .m_rdata(m_rdata)
`ifdef MEM_ARB_PERF_CNT_EN
    , .perf_i_wait(perf_i_wait), .perf_d_wait(perf_d_wait), .perf_timeout(perf_timeout)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory behaviour knobs: gnt_mode/rv_mode -1 = random, rv_mode -2 = never respond.
  int gnt_mode = 0, rv_mode = 0;
  bit spur_en = 1'b0, force_rv = 1'b0, fix_en = 1'b1;
  logic [31:0] fix_data = '0;
  int phase = 0, gw = 0, rw = 0;

  // Memory responder, driven just after each rising edge.
  always @(posedge clk) begin
    int p0;
    #1;
    m_gnt = 1'b0; m_rvalid = 1'b0;
    if (!rst_n) begin
      phase = 0;
    end else begin
      if (phase == 2 && (i_rvalid || d_rvalid)) phase = 0;
      p0 = phase;
      if (phase == 0 && m_req) begin
        phase = 1;
        gw = (gnt_mode < 0) ? int'($urandom % 4) : gnt_mode;
      end
      if (phase == 1) begin
        if (gw == 0) begin
          m_gnt = 1'b1; phase = 2;
          if (rv_mode == -2) rw = 1000;
          else if (rv_mode == -1) rw = ($urandom % 8 == 7) ? 1000 : int'($urandom % 4);
          else rw = rv_mode;
        end else gw--;
      end else if (phase == 2) begin
        if (rw == 0) begin
          m_rvalid = 1'b1; m_rdata = fix_en ? fix_data : $urandom; phase = 0;
        end else rw--;
      end
      if (spur_en && p0 != 2 && ($urandom % 8 == 0)) begin
        m_rvalid = 1'b1; m_rdata = $urandom;
      end
      if (force_rv) begin
        m_rvalid = 1'b1; m_rdata = 32'h12345678;
      end
    end
  end

  // Reference model: one transaction in flight, tracked as (who, granted?, cycles waited).
  bit mb_busy = 0, mb_granted = 0, mb_is_d = 0, mb_we = 0;
  logic [31:0] mb_addr = '0, mb_wdata = '0;
  int mb_age = 0, mb_streak = 0;
  bit md_valid = 0, md_is_d = 0, md_err = 0;
  logic [31:0] md_data = '0;

  // Compare process: checks every output every cycle, then advances the model.
  always @(negedge clk) begin
    bit e_mreq, pick_d;
    if (!rst_n) begin
      mb_busy = 0; mb_granted = 0; mb_streak = 0; md_valid = 0;
      check("rst_outs", {m_req, m_we, i_gnt, d_gnt, i_rvalid, d_rvalid, i_err, d_err}, 64'd0);
      check("rst_mdata", {m_addr, m_wdata}, 64'd0);
    end else begin
      e_mreq = mb_busy && !mb_granted;
      check("m_req", m_req, e_mreq);
      if (e_mreq) begin
        check("m_addr", m_addr, mb_addr);
        check("m_we", m_we, mb_we);
        if (mb_we) check("m_wdata", m_wdata, mb_wdata);
      end
      check("i_gnt", i_gnt, e_mreq && !mb_is_d && m_gnt);
      check("d_gnt", d_gnt, e_mreq && mb_is_d && m_gnt);
      check("i_rvalid", i_rvalid, md_valid && !md_is_d);
      check("d_rvalid", d_rvalid, md_valid && md_is_d);
      check("i_err", i_err, md_valid && !md_is_d && md_err);
      check("d_err", d_err, md_valid && md_is_d && md_err);
      if (md_valid && !md_is_d) check("i_rdata", i_rdata, md_data);
      if (md_valid && md_is_d) check("d_rdata", d_rdata, md_data);
      md_valid = 0;
      if (mb_busy && mb_granted) begin
        if (m_rvalid) begin
          md_valid = 1; md_is_d = mb_is_d; md_err = 0; md_data = m_rdata; mb_busy = 0;
        end else if (mb_age == TO - 1) begin
          md_valid = 1; md_is_d = mb_is_d; md_err = 1; md_data = '0; mb_busy = 0;
        end else mb_age++;
      end else if (mb_busy) begin
        if (m_gnt) begin mb_granted = 1; mb_age = 0; end
      end else begin
        pick_d = d_req && !(i_req && mb_streak == MAXB);
        if (pick_d) begin
          mb_busy = 1; mb_granted = 0; mb_is_d = 1; mb_we = d_we; mb_addr = d_addr; mb_wdata = d_wdata;
          mb_streak = i_req ? ((mb_streak < MAXB) ? mb_streak + 1 : mb_streak) : 0;
        end else if (i_req) begin
          mb_busy = 1; mb_granted = 0; mb_is_d = 0; mb_we = 0; mb_addr = i_addr; mb_streak = 0;
        end
      end
    end
  end

  task automatic run_txn(input bit is_d, input logic [31:0] addr, output int t0, output int gc,
                         output int rc, output logic [31:0] rd, output logic er);
    bit g, r;
    gc = -1; rc = -1; rd = '0; er = 1'b0;
    @(posedge clk); #1;
    if (is_d) begin d_req = 1'b1; d_we = 1'b0; d_addr = addr; end
    else begin i_req = 1'b1; i_addr = addr; end
    t0 = cyc;
    for (int k = 0; k < 40 && rc < 0; k++) begin
      @(negedge clk);
      g = is_d ? d_gnt : i_gnt;
      r = is_d ? d_rvalid : i_rvalid;
      if (g) gc = cyc;
      if (r) begin rc = cyc; rd = is_d ? d_rdata : i_rdata; er = is_d ? d_err : i_err; end
      @(posedge clk); #1;
      if (g) begin if (is_d) d_req = 1'b0; else i_req = 1'b0; end
    end
    i_req = 1'b0; d_req = 1'b0;
  endtask

  initial begin
    int t0, gc, rc, ng;
    logic [31:0] rd;
    logic er, ig, dg;
    bit seq[6];
    logic [63:0] first_m;
`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] p0;
`endif
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("reset_m_req", m_req, 64'd0);
    check("reset_rvalid", {i_rvalid, d_rvalid}, 64'd0);

    // Single fetch with zero-wait memory.
    gnt_mode = 0; rv_mode = 0; fix_data = 32'h00500093;
    run_txn(1'b0, 32'h100, t0, gc, rc, rd, er);
    check("fetch_gnt_lat", 64'(gc - t0), 64'd1);
    check("fetch_rv_lat", 64'(rc - t0), 64'd3);
    check("fetch_rdata", rd, 64'h00500093);
    check("fetch_err", er, 64'd0);
    repeat (2) @(posedge clk);

    // Contention: D store and I fetch raised together.
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = 32'h300;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF;
    ng = 0; first_m = '0;
    for (int k = 0; k < 40 && ng < 2; k++) begin
      @(negedge clk);
      ig = i_gnt; dg = d_gnt;
      if (ig || dg) begin
        if (ng == 0) first_m = {31'd0, m_we, m_addr};
        seq[ng] = dg; ng++;
        if (ng == 1) check("cont_wdata", m_wdata, 64'hDEADBEEF);
      end
      @(posedge clk); #1;
      if (ig) i_req = 1'b0;
      if (dg) d_req = 1'b0;
    end
    check("cont_first_is_d", seq[0], 64'd1);
    check("cont_second_is_i", seq[1], 64'd0);
    check("cont_m_we_addr", first_m, {31'd0, 1'b1, 32'h200});
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    repeat (6) @(posedge clk);

    // Starvation guard: D held continuously while I waits.
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = 32'h340; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
    ng = 0;
    for (int k = 0; k < 80 && ng < 6; k++) begin
      @(negedge clk);
      ig = i_gnt; dg = d_gnt;
      if (ig || dg) begin seq[ng] = dg; ng++; end
      @(posedge clk); #1;
      if (ig) i_req = 1'b0;
      if (dg) d_addr = d_addr + 32'd4;
    end
    d_req = 1'b0;
    check("starve_grants", ng, 64'd6);
    check("starve_d4", {seq[0], seq[1], seq[2], seq[3]}, 64'hF);
    check("starve_5th_i", seq[4], 64'd0);
    check("starve_6th_d", seq[5], 64'd1);
    repeat (8) @(posedge clk);

    // Timeout: memory grants but never responds.
    rv_mode = -2;
    run_txn(1'b1, 32'h400, t0, gc, rc, rd, er);
    check("to_latency", 64'(rc - gc), 64'd9);
    check("to_err", er, 64'd1);
    check("to_rdata", rd, 64'd0);
    repeat (2) @(posedge clk);

    // Reset asserted in the middle of RESP.
    @(posedge clk); #1;
    d_req = 1'b1; d_addr = 32'h500; d_we = 1'b0;
    for (int k = 0; k < 20 && !d_gnt; k++) @(negedge clk);
    check("rst_test_gnt", d_gnt, 64'd1);
    @(posedge clk); #3;
    d_req = 1'b0; rst_n = 1'b0;
    #1;
    check("rst_async_ctl", {m_req, d_gnt, d_rvalid, d_err, i_rvalid, i_err}, 64'd0);
    check("rst_async_data", {m_addr, d_rdata}, 64'd0);
    @(posedge clk); #2;
    rst_n = 1'b1; force_rv = 1'b1;
    @(posedge clk); #3;
    force_rv = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("late_rv_ignored", {i_rvalid, d_rvalid}, 64'd0);
    end

`ifdef MEM_ARB_PERF_CNT_EN
    gnt_mode = 5; rv_mode = 0;
    p0 = perf_d_wait;
    run_txn(1'b1, 32'h700, t0, gc, rc, rd, er);
    check("perf_d_wait", perf_d_wait - p0, 64'd6);
`endif

    // Randomized traffic with random memory timing and stray completions.
    gnt_mode = -1; rv_mode = -1; spur_en = 1'b1; fix_en = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      ig = i_gnt; dg = d_gnt;
      @(posedge clk); #1;
      if (ig) i_req = 1'b0;
      if (dg) d_req = 1'b0;
      if (!i_req && ($urandom % 3 == 0)) begin i_req = 1'b1; i_addr = $urandom; end
      if (!d_req && ($urandom % 3 == 0)) begin
        d_req = 1'b1; d_we = 1'($urandom % 2); d_addr = $urandom; d_wdata = $urandom;
      end
    end
    i_req = 1'b0; d_req = 1'b0; spur_en = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
